// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - Self-synchronising Fibonacci LFSR stream checker with lock, flywheel and error count.
module lfsr_checker #(
    parameter int N          = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [N-1:0]     mask,
    input  logic             valid,
    input  logic [N-1:0]     din,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [N-1:0]     r_prev;
    logic [N-1:0]     r_mask;
    logic [MW-1:0]    r_match;
    logic [XW-1:0]    r_miss;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic [N-1:0]     w_pred;
    logic             w_hit;
    logic             w_din_zero;
    logic [MW-1:0]    w_match_nxt;
    logic [XW-1:0]    w_miss_nxt;
    logic             w_match_done;
    logic             w_miss_done;
    logic             w_cnt_full;

    logic             w_seed;
    logic             w_load_din;
    logic             w_load_pred;
    logic             w_match_clr;
    logic             w_match_inc;
    logic             w_miss_clr;
    logic             w_miss_inc;
    logic             w_err_set;
    logic             w_locked;

    // Generator's next state: shift left, parity of tapped bits enters at bit 0.
    assign w_pred       = {r_prev[N-2:0], ^(r_mask & r_prev)};
    assign w_hit        = (din == w_pred);
    assign w_din_zero   = (din == '0);
    assign w_match_nxt  = r_match + MW'(1);
    assign w_miss_nxt   = r_miss + XW'(1);
    assign w_match_done = (w_match_nxt == MW'(LOCK_CNT));
    assign w_miss_done  = (w_miss_nxt == XW'(UNLOCK_CNT));
    assign w_cnt_full   = &r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clr) begin
            w_next_state = S_HUNT;
        end else if (valid) begin
            case (r_state)
                S_HUNT: begin
                    if (!w_din_zero) begin
                        w_next_state = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (w_hit) begin
                        if (w_match_done) begin
                            w_next_state = S_LOCKED;
                        end
                    end else if (w_din_zero) begin
                        w_next_state = S_HUNT;
                    end
                end
                S_LOCKED: begin
                    if (!w_hit && w_miss_done) begin
                        w_next_state = S_HUNT;
                    end
                end
                default: begin
                    w_next_state = S_HUNT;
                end
            endcase
        end
    end

    always_comb begin
        w_seed      = 1'b0;
        w_load_din  = 1'b0;
        w_load_pred = 1'b0;
        w_match_clr = 1'b0;
        w_match_inc = 1'b0;
        w_miss_clr  = 1'b1;
        w_miss_inc  = 1'b0;
        w_err_set   = 1'b0;
        w_locked    = 1'b0;
        case (r_state)
            S_HUNT: begin
                w_seed      = valid && !w_din_zero;
                w_load_din  = w_seed;
                w_match_clr = w_seed;
            end
            S_VERIFY: begin
                w_load_din  = valid;
                w_match_inc = valid && w_hit;
                w_match_clr = valid && !w_hit;
            end
            S_LOCKED: begin
                w_locked    = 1'b1;
                w_load_din  = valid && w_hit;
                // Flywheel: on a bad word keep running on our own prediction.
                w_load_pred = valid && !w_hit;
                w_miss_clr  = valid && w_hit;
                w_miss_inc  = valid && !w_hit;
                w_err_set   = valid && !w_hit;
            end
            default: begin
                w_locked = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= '0;
            r_mask    <= '0;
            r_match   <= '0;
            r_miss    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (clr) begin
            r_prev    <= '0;
            r_mask    <= '0;
            r_match   <= '0;
            r_miss    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_err_set;
            if (w_load_din) begin
                r_prev <= din;
            end else if (w_load_pred) begin
                r_prev <= w_pred;
            end
            if (w_seed) begin
                r_mask <= mask;
            end
            if (w_match_clr) begin
                r_match <= '0;
            end else if (w_match_inc && !w_match_done) begin
                r_match <= w_match_nxt;
            end
            if (w_miss_clr) begin
                r_miss <= '0;
            end else if (w_miss_inc) begin
                r_miss <= w_miss_nxt;
            end
            if (w_err_set && !w_cnt_full) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign locked  = w_locked;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - Randomized self-checking bench for lfsr_checker against a word-level reference model.
module tb_lfsr_checker;

    localparam int N      = 32;
    localparam int HUNT   = 0;
    localparam int VERIFY = 1;
    localparam int LOCKED = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic [N-1:0]  mask;
    logic          valid;
    logic [N-1:0]  din;
    logic          locked_a, err_a, locked_b, err_b;
    logic [15:0]   cnt_a;
    logic [2:0]    cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    int           m_mode;
    logic [N-1:0] m_prev, m_mask;
    int           m_run, m_miss, m_errs;
    bit           m_err;

    logic [N-1:0] g_state, g_mask;
    bit           mask_noise = 1'b0;

    always #5 clk = ~clk;

    lfsr_checker #(.N(N), .LOCK_CNT(4), .UNLOCK_CNT(4), .ERR_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mask(mask), .valid(valid), .din(din),
        .locked(locked_a), .err(err_a), .err_cnt(cnt_a)
    );

    lfsr_checker #(.N(N), .LOCK_CNT(4), .UNLOCK_CNT(4), .ERR_W(3)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mask(mask), .valid(valid), .din(din),
        .locked(locked_b), .err(err_b), .err_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s, input logic [N-1:0] m);
        logic fb;
        fb = ($countones(s & m) % 2) == 1;
        return {s[N-2:0], fb};
    endfunction

    task automatic model_clear();
        m_mode = HUNT; m_prev = '0; m_mask = '0;
        m_run = 0; m_miss = 0; m_errs = 0; m_err = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit c, input logic [N-1:0] d, input logic [N-1:0] mk);
        logic [N-1:0] pred;
        m_err = 1'b0;
        if (c) begin
            model_clear();
        end else if (v) begin
            pred = lfsr_next(m_prev, m_mask);
            if (m_mode == HUNT) begin
                if (d != 0) begin
                    m_prev = d; m_mask = mk; m_run = 0; m_mode = VERIFY;
                end
            end else if (m_mode == VERIFY) begin
                if (d == pred) begin
                    m_prev = d; m_run++;
                    if (m_run == 4) begin m_mode = LOCKED; m_miss = 0; end
                end else if (d == 0) begin
                    m_mode = HUNT;
                end else begin
                    m_prev = d; m_run = 0;
                end
            end else begin
                if (d == pred) begin
                    m_prev = d; m_miss = 0;
                end else begin
                    m_prev = pred; m_err = 1'b1; m_errs++; m_miss++;
                    if (m_miss == 4) m_mode = HUNT;
                end
            end
        end
    endtask

    task automatic drive_word(input bit v, input logic [N-1:0] d, input logic [N-1:0] mk, input bit c);
        valid = v; din = d; mask = mk; clr = c;
        @(posedge clk);
        #1;
        model_step(v, c, d, mk);
        check("locked", {63'd0, locked_a}, {63'd0, m_mode == LOCKED});
        check("err", {63'd0, err_a}, {63'd0, m_err});
        check("err_cnt", 64'(cnt_a), 64'((m_errs > 65535) ? 65535 : m_errs));
        check("locked_sat", {63'd0, locked_b}, {63'd0, m_mode == LOCKED});
        check("err_cnt_sat", 64'(cnt_b), 64'((m_errs > 7) ? 7 : m_errs));
        valid = 1'b0; clr = 1'b0;
    endtask

    task automatic send(input bit v, input logic [N-1:0] flip);
        logic [N-1:0] mk;
        mk = (mask_noise && m_mode != HUNT && $urandom_range(1, 0) == 1) ? N'($urandom) : g_mask;
        if (v) begin
            drive_word(1'b1, g_state ^ flip, mk, 1'b0);
            g_state = lfsr_next(g_state, g_mask);
        end else begin
            drive_word(1'b0, N'($urandom), mk, 1'b0);
        end
    endtask

    task automatic do_clr();
        drive_word(1'b0, '0, g_mask, 1'b1);
    endtask

    task automatic words_to_lock(input string tag, input int exp);
        int nv;
        nv = 0;
        for (int i = 0; i < 40 && !locked_a; i++) begin
            send(1'b1, '0);
            nv++;
        end
        check(tag, 64'(nv), 64'(exp));
    endtask

    initial begin
        int lock_at;
        int nv;
        rst_n = 1'b0; clr = 1'b0; valid = 1'b0; din = '0; mask = '0;
        model_clear();
        #12;
        check("rst_locked", {63'd0, locked_a}, 64'd0);
        check("rst_err", {63'd0, err_a}, 64'd0);
        check("rst_err_cnt", 64'(cnt_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        g_mask = 32'h8000_0057; g_state = 32'h1;
        lock_at = 0;
        for (int k = 1; k <= 10000; k++) begin
            send(1'b1, '0);
            if (locked_a && lock_at == 0) lock_at = k;
        end
        check("t1_lock_word", 64'(lock_at), 64'd5);
        check("t1_err_cnt", 64'(cnt_a), 64'd0);

        drive_word(1'b1, N'($urandom), g_mask, 1'b1);
        check("t6_clr_valid_locked", {63'd0, locked_a}, 64'd0);
        g_state = 32'h1; nv = 0;
        for (int i = 0; i < 400 && !locked_a; i++) begin
            if ($urandom_range(1, 0) == 1) begin send(1'b1, '0); nv++; end
            else send(1'b0, '0);
        end
        check("t2_gap_lock_words", 64'(nv), 64'd5);
        for (int i = 0; i < 200; i++) send($urandom_range(1, 0) == 1, '0);

        do_clr();
        words_to_lock("t3_relock", 5);
        for (int i = 0; i < 8; i++) send(1'b1, '0);
        send(1'b1, 32'h1);
        check("t3_err_pulse", {63'd0, err_a}, 64'd1);
        check("t3_err_cnt", 64'(cnt_a), 64'd1);
        check("t3_locked", {63'd0, locked_a}, 64'd1);
        send(1'b1, '0);
        check("t3_err_once", {63'd0, err_a}, 64'd0);
        for (int i = 0; i < 20; i++) send(1'b1, '0);
        check("t3_err_cnt_hold", 64'(cnt_a), 64'd1);

        do_clr();
        words_to_lock("t4_lock", 5);
        for (int i = 0; i < 4; i++) send(1'b1, N'($urandom) | 32'h1);
        check("t4_err_cnt", 64'(cnt_a), 64'd4);
        check("t4_unlocked", {63'd0, locked_a}, 64'd0);
        words_to_lock("t4_relock", 5);
        check("t4_err_cnt_kept", 64'(cnt_a), 64'd4);

        do_clr();
        for (int i = 0; i < 50; i++) drive_word(1'b1, '0, g_mask, 1'b0);
        check("t5a_zero_hunt", {63'd0, locked_a}, 64'd0);

        do_clr();
        words_to_lock("t5b_lock", 5);
        for (int e = 0; e < 10; e++) begin
            send(1'b1, 32'h1 << $urandom_range(31, 0));
            for (int i = 0; i < 3; i++) send(1'b1, '0);
        end
        check("t5b_sat", 64'(cnt_b), 64'd7);
        check("t5b_wide", 64'(cnt_a), 64'd10);
        check("t5b_locked", {63'd0, locked_a}, 64'd1);

        #2 rst_n = 1'b0;
        #1;
        check("t6_async_locked", {63'd0, locked_a}, 64'd0);
        check("t6_async_err_cnt", 64'(cnt_a), 64'd0);
        check("t6_async_err_cnt_sat", 64'(cnt_b), 64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        words_to_lock("t6_relock", 5);
        send(1'b1, 32'h2);
        drive_word(1'b1, g_state, g_mask, 1'b1);
        check("t6_clr_err_cnt", 64'(cnt_a), 64'd0);
        check("t6_clr_locked", {63'd0, locked_a}, 64'd0);

        mask_noise = 1'b1;
        for (int r = 0; r < 6; r++) begin
            do_clr();
            g_mask  = N'($urandom) | 32'h8000_0000;
            g_state = N'($urandom) | 32'h1;
            for (int i = 0; i < 1500; i++) begin
                send($urandom_range(3, 0) != 0,
                     ($urandom_range(19, 0) == 0) ? (32'h1 << $urandom_range(31, 0)) : '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
